// File: rtl/cpu_debug_cmd_sysclk_multi_pkg.sv
// rtl/cpu_debug_cmd_sysclk_multi_pkg.sv - shared types, defaults and channel decode for the debug command block
package cpu_debug_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    ISSUE  = 2'd2,
    HOLD   = 2'd3
  } state_e;

  localparam int DATA_W_DEF      = 38;
  localparam int IR_W_DEF        = 2;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int ACT_BIT_DEF     = 34;
  localparam int CNT_W_DEF       = 4;

  // Widest supported instruction; callers cast the result down to their channel count.
  localparam int MAX_IR_W = 8;
  localparam int MAX_CH   = 2 ** MAX_IR_W;

  function automatic logic [MAX_CH-1:0] onehot_ch(input logic [MAX_IR_W-1:0] ir);
    logic [MAX_CH-1:0] oh;
    oh     = '0;
    oh[ir] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/cpu_debug_cmd_sysclk_multi_if.sv
// rtl/cpu_debug_cmd_sysclk_multi_if.sv - JTAG-side capture inputs and consumer-side command outputs
interface cpu_debug_cmd_sysclk_multi_if
  import cpu_debug_cmd_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int IR_W   = IR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) ();
  localparam int NUM_CH = 2 ** IR_W;

  logic [DATA_W-1:0] sr;
  logic [IR_W-1:0]   ir_in;
  logic              vs_udr;
  logic              vs_uir;
  logic              cmd_ready;
  logic              overrun_clr;
  logic [DATA_W-1:0] jdo;
  logic [IR_W-1:0]   ir_q;
  logic [NUM_CH-1:0] take_action;
  logic [NUM_CH-1:0] take_no_action;
  logic              cmd_valid;
  logic              busy;
  logic              overrun;
  logic [CNT_W-1:0]  overrun_cnt;
  logic              parity_err;

  modport slave (
    input  sr, ir_in, vs_udr, vs_uir, cmd_ready, overrun_clr,
    output jdo, ir_q, take_action, take_no_action, cmd_valid, busy,
           overrun, overrun_cnt, parity_err
  );

  modport master (
    output sr, ir_in, vs_udr, vs_uir, cmd_ready, overrun_clr,
    input  jdo, ir_q, take_action, take_no_action, cmd_valid, busy,
           overrun, overrun_cnt, parity_err
  );
endinterface

// File: rtl/cpu_debug_cmd_sysclk_multi_sync_edge.sv
// rtl/cpu_debug_cmd_sysclk_multi_sync_edge.sv - multi-flop synchroniser with rising-edge detect
module cpu_debug_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic edge_o
);
  logic [STAGES-1:0] sync_q;
  logic              hist_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
      hist_q <= sync_q[STAGES-1];
    end
  end

  assign edge_o = sync_q[STAGES-1] & ~hist_q;
endmodule

// File: rtl/cpu_debug_cmd_sysclk_multi.sv
// rtl/cpu_debug_cmd_sysclk_multi.sv - system-clock half of the CPU debug slave
// Optional odd-parity check on jdo enabled by CPU_DEBUG_CMD_PARITY_EN.
module cpu_debug_cmd_sysclk_multi
  import cpu_debug_cmd_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int IR_W        = IR_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int ACT_BIT     = ACT_BIT_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input logic clk,
  input logic reset,
  cpu_debug_cmd_sysclk_multi_if.slave bus
);
  localparam int NUM_CH = 2 ** IR_W;

  state_e            state_q;
  logic [DATA_W-1:0] jdo_q;
  logic [IR_W-1:0]   ir_q_q;
  logic [NUM_CH-1:0] act_q;
  logic [NUM_CH-1:0] noact_q;
  logic              valid_q;
  logic              ovr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              udr_edge;
  logic              uir_edge;
  logic [NUM_CH-1:0] ch;

  cpu_debug_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_udr (
    .clk(clk), .reset(reset), .async_i(bus.vs_udr), .edge_o(udr_edge)
  );

  cpu_debug_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_uir (
    .clk(clk), .reset(reset), .async_i(bus.vs_uir), .edge_o(uir_edge)
  );

  assign ch = NUM_CH'(onehot_ch(MAX_IR_W'(ir_q_q)));

`ifdef CPU_DEBUG_CMD_PARITY_EN
  logic perr_q;
  assign bus.parity_err = perr_q;
`else
  assign bus.parity_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      jdo_q   <= '0;
      ir_q_q  <= '0;
      act_q   <= '0;
      noact_q <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      cnt_q   <= '0;
`ifdef CPU_DEBUG_CMD_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      act_q   <= '0;
      noact_q <= '0;

      // A clear in the same cycle as a drop wins, leaving the counter at zero.
      if (bus.overrun_clr) begin
        ovr_q <= 1'b0;
        cnt_q <= '0;
`ifdef CPU_DEBUG_CMD_PARITY_EN
        perr_q <= 1'b0;
`endif
      end else if (udr_edge && state_q != IDLE) begin
        ovr_q <= 1'b1;
        if (cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + CNT_W'(1);
      end

      if (uir_edge) begin
        state_q <= IDLE;
        valid_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (udr_edge) begin
              jdo_q   <= bus.sr;
              ir_q_q  <= bus.ir_in;
              state_q <= DECODE;
            end
          end
          DECODE: begin
`ifdef CPU_DEBUG_CMD_PARITY_EN
            if (!(^jdo_q)) begin
              perr_q  <= 1'b1;
              state_q <= IDLE;
            end else
`endif
            begin
              state_q <= ISSUE;
              valid_q <= 1'b1;
              if (jdo_q[ACT_BIT]) act_q   <= ch;
              else                noact_q <= ch;
            end
          end
          ISSUE, HOLD: begin
            if (bus.cmd_ready) begin
              state_q <= IDLE;
              valid_q <= 1'b0;
            end else begin
              state_q <= HOLD;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.jdo            = jdo_q;
  assign bus.ir_q           = ir_q_q;
  assign bus.take_action    = act_q;
  assign bus.take_no_action = noact_q;
  assign bus.cmd_valid      = valid_q;
  assign bus.busy           = (state_q != IDLE);
  assign bus.overrun        = ovr_q;
  assign bus.overrun_cnt    = cnt_q;
endmodule

// File: tb/tb_cpu_debug_cmd_sysclk_multi.sv
// tb/tb_cpu_debug_cmd_sysclk_multi.sv - directed self-checking bench for cpu_debug_cmd_sysclk_multi
module tb_cpu_debug_cmd_sysclk_multi;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  cpu_debug_cmd_sysclk_multi_if #(.DATA_W(38), .IR_W(2), .CNT_W(4)) bus ();

  cpu_debug_cmd_sysclk_multi #(
    .DATA_W(38), .IR_W(2), .SYNC_STAGES(2), .ACT_BIT(34), .CNT_W(4)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic udr_pulse(input int hi, input int lo);
    bus.vs_udr = 1'b1;
    step(hi);
    bus.vs_udr = 1'b0;
    step(lo);
  endtask

  // Issues one update with cmd_ready as currently driven and records what came out.
  task automatic run_cmd(input logic [37:0] sr, input logic [1:0] ir,
                         output logic [3:0] act_or, output logic [3:0] noact_or,
                         output int pulses, output int vcnt);
    act_or = '0; noact_or = '0; pulses = 0; vcnt = 0;
    bus.sr = sr; bus.ir_in = ir; bus.vs_udr = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (i == 2) bus.vs_udr = 1'b0;
      act_or   |= bus.take_action;
      noact_or |= bus.take_no_action;
      if (bus.take_action != 0 || bus.take_no_action != 0) pulses++;
      if (bus.cmd_valid) vcnt++;
    end
  endtask

  task automatic test_reset;
    step(2);
    tests_run++; if (bus.jdo !== 38'h0) begin tests_failed++; $display("FAIL reset_jdo: got %h expected 0", bus.jdo); end
    tests_run++; if (bus.busy !== 1'b0 || bus.cmd_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_busy_valid: got %b%b expected 00", bus.busy, bus.cmd_valid); end
    tests_run++; if (bus.overrun !== 1'b0 || bus.overrun_cnt !== 4'h0) begin tests_failed++; $display("FAIL reset_overrun: got %b/%h expected 0/0", bus.overrun, bus.overrun_cnt); end
    tests_run++; if (bus.take_action !== 4'h0 || bus.take_no_action !== 4'h0 || bus.parity_err !== 1'b0) begin tests_failed++; $display("FAIL reset_pulses: got %b %b %b expected 0", bus.take_action, bus.take_no_action, bus.parity_err); end
    reset = 1'b0;
    step(2);
    tests_run++; if (bus.busy !== 1'b0 || bus.ir_q !== 2'd0) begin tests_failed++; $display("FAIL post_reset_idle: busy %b ir_q %0d expected 0 0", bus.busy, bus.ir_q); end
  endtask

  task automatic test_action;
    bus.sr = 38'h4_0000_1234; bus.ir_in = 2'd2; bus.cmd_ready = 1'b1; bus.vs_udr = 1'b1;
    step(2);
    tests_run++; if (bus.jdo !== 38'h0) begin tests_failed++; $display("FAIL act_jdo_early: got %h expected 0", bus.jdo); end
    step(1);
    bus.vs_udr = 1'b0;
    tests_run++; if (bus.jdo !== 38'h4_0000_1234 || bus.ir_q !== 2'd2) begin tests_failed++; $display("FAIL act_capture: got %h/%0d expected 400001234/2", bus.jdo, bus.ir_q); end
    tests_run++; if (bus.busy !== 1'b1 || bus.take_action !== 4'h0) begin tests_failed++; $display("FAIL act_decode: busy %b act %b expected 1 0000", bus.busy, bus.take_action); end
    step(1);
    tests_run++; if (bus.take_action !== 4'b0100 || bus.take_no_action !== 4'b0000 || bus.cmd_valid !== 1'b1) begin tests_failed++; $display("FAIL act_pulse: got %b %b %b expected 0100 0000 1", bus.take_action, bus.take_no_action, bus.cmd_valid); end
    step(1);
    tests_run++; if (bus.take_action !== 4'h0 || bus.busy !== 1'b0 || bus.cmd_valid !== 1'b0) begin tests_failed++; $display("FAIL act_done: act %b busy %b valid %b expected 0000 0 0", bus.take_action, bus.busy, bus.cmd_valid); end
  endtask

  task automatic test_no_action_hold;
    int vcnt = 0, ncnt = 0, acnt = 0, bad = 0;
    bus.sr = 38'h0_0000_5678; bus.ir_in = 2'd0; bus.cmd_ready = 1'b0; bus.vs_udr = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (i == 2) bus.vs_udr = 1'b0;
      if (bus.cmd_valid) vcnt++;
      if (bus.take_no_action == 4'b0001) ncnt++;
      else if (bus.take_no_action != 4'h0) bad++;
      if (bus.take_action != 4'h0) acnt++;
      if (vcnt == 6 && bus.cmd_valid) bus.cmd_ready = 1'b1;
    end
    bus.cmd_ready = 1'b0;
    tests_run++; if (vcnt !== 6) begin tests_failed++; $display("FAIL hold_valid_cycles: got %0d expected 6", vcnt); end
    tests_run++; if (ncnt !== 1 || bad !== 0 || acnt !== 0) begin tests_failed++; $display("FAIL hold_pulses: noact %0d other %0d act %0d expected 1 0 0", ncnt, bad, acnt); end
    tests_run++; if (bus.cmd_valid !== 1'b0 || bus.busy !== 1'b0) begin tests_failed++; $display("FAIL hold_release: valid %b busy %b expected 0 0", bus.cmd_valid, bus.busy); end
  endtask

  task automatic test_overrun;
    bus.sr = 38'h1_2345_6789; bus.ir_in = 2'd1; bus.cmd_ready = 1'b0;
    udr_pulse(3, 4);
    tests_run++; if (bus.busy !== 1'b1 || bus.cmd_valid !== 1'b1 || bus.overrun !== 1'b0) begin tests_failed++; $display("FAIL ovr_in_hold: busy %b valid %b ovr %b expected 1 1 0", bus.busy, bus.cmd_valid, bus.overrun); end
    bus.sr = 38'h3F_FFFF_FFFF;
    udr_pulse(3, 4);
    tests_run++; if (bus.overrun !== 1'b1 || bus.overrun_cnt !== 4'd1 || bus.jdo !== 38'h1_2345_6789) begin tests_failed++; $display("FAIL ovr_first: ovr %b cnt %0d jdo %h expected 1 1 123456789", bus.overrun, bus.overrun_cnt, bus.jdo); end
    for (int i = 0; i < 20; i++) udr_pulse(2, 3);
    tests_run++; if (bus.overrun_cnt !== 4'd15 || bus.jdo !== 38'h1_2345_6789 || bus.cmd_valid !== 1'b1) begin tests_failed++; $display("FAIL ovr_saturate: cnt %0d jdo %h valid %b expected 15 123456789 1", bus.overrun_cnt, bus.jdo, bus.cmd_valid); end
    bus.overrun_clr = 1'b1;
    step(1);
    bus.overrun_clr = 1'b0;
    tests_run++; if (bus.overrun !== 1'b0 || bus.overrun_cnt !== 4'd0) begin tests_failed++; $display("FAIL ovr_clear: ovr %b cnt %0d expected 0 0", bus.overrun, bus.overrun_cnt); end
    bus.cmd_ready = 1'b1;
    step(1);
    tests_run++; if (bus.busy !== 1'b0 || bus.cmd_valid !== 1'b0) begin tests_failed++; $display("FAIL ovr_exit_hold: busy %b valid %b expected 0 0", bus.busy, bus.cmd_valid); end
  endtask

  task automatic test_abort;
    int seen = 0;
    bus.sr = 38'h0_0000_00AA; bus.ir_in = 2'd1; bus.cmd_ready = 1'b1; bus.vs_udr = 1'b1;
    step(1);
    bus.vs_uir = 1'b1;
    step(2);
    bus.vs_udr = 1'b0; bus.vs_uir = 1'b0;
    tests_run++; if (bus.busy !== 1'b1 || bus.jdo !== 38'h0_0000_00AA) begin tests_failed++; $display("FAIL abort_in_decode: busy %b jdo %h expected 1 aa", bus.busy, bus.jdo); end
    for (int i = 0; i < 6; i++) begin
      step(1);
      if (bus.take_action != 0 || bus.take_no_action != 0 || bus.cmd_valid) seen++;
    end
    tests_run++; if (seen !== 0 || bus.busy !== 1'b0) begin tests_failed++; $display("FAIL abort_suppress: activity %0d busy %b expected 0 0", seen, bus.busy); end
    seen = 0;
    bus.sr = 38'h4_0000_0F0F; bus.ir_in = 2'd3; bus.vs_udr = 1'b1; bus.vs_uir = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (i == 2) begin bus.vs_udr = 1'b0; bus.vs_uir = 1'b0; end
      if (bus.busy || bus.cmd_valid || bus.take_action != 0) seen++;
    end
    tests_run++; if (seen !== 0 || bus.jdo !== 38'h0_0000_00AA || bus.overrun !== 1'b0) begin tests_failed++; $display("FAIL abort_simul: activity %0d jdo %h ovr %b expected 0 aa 0", seen, bus.jdo, bus.overrun); end
  endtask

  task automatic test_reset_mid;
    int seen = 0;
    bus.sr = 38'h2_0000_0001; bus.ir_in = 2'd3; bus.cmd_ready = 1'b0;
    udr_pulse(3, 3);
    udr_pulse(3, 3);
    tests_run++; if (bus.busy !== 1'b1 || bus.overrun !== 1'b1) begin tests_failed++; $display("FAIL rst_pre: busy %b ovr %b expected 1 1", bus.busy, bus.overrun); end
    #2 reset = 1'b1;
    #1;
    tests_run++; if (bus.jdo !== 38'h0 || bus.ir_q !== 2'd0 || bus.busy !== 1'b0 || bus.cmd_valid !== 1'b0 || bus.overrun !== 1'b0 || bus.overrun_cnt !== 4'd0) begin tests_failed++; $display("FAIL rst_async: jdo %h ir %0d busy %b valid %b ovr %b cnt %0d expected all 0", bus.jdo, bus.ir_q, bus.busy, bus.cmd_valid, bus.overrun, bus.overrun_cnt); end
    step(1);
    reset = 1'b0;
    bus.cmd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (bus.take_action != 0 || bus.take_no_action != 0 || bus.cmd_valid || bus.busy) seen++;
    end
    tests_run++; if (seen !== 0) begin tests_failed++; $display("FAIL rst_no_pulse: activity %0d expected 0", seen); end
  endtask

  task automatic test_back_to_back;
    logic [3:0] a, n;
    int p, v;
    bus.cmd_ready = 1'b1;
    run_cmd(38'h0_0000_0001, 2'd1, a, n, p, v);
    tests_run++; if (a !== 4'b0000 || n !== 4'b0010 || p !== 1 || v !== 1) begin tests_failed++; $display("FAIL b2b_first: act %b noact %b pulses %0d valid %0d expected 0000 0010 1 1", a, n, p, v); end
    run_cmd(38'h4_0000_0002, 2'd3, a, n, p, v);
    tests_run++; if (a !== 4'b1000 || n !== 4'b0000 || p !== 1 || v !== 1 || bus.jdo !== 38'h4_0000_0002) begin tests_failed++; $display("FAIL b2b_second: act %b noact %b pulses %0d valid %0d jdo %h expected 1000 0000 1 1 400000002", a, n, p, v, bus.jdo); end
  endtask

  task automatic test_parity;
    logic [3:0] a, n;
    int p, v;
    bus.cmd_ready = 1'b1;
    run_cmd(38'h04_0000_0001, 2'd2, a, n, p, v);
`ifdef CPU_DEBUG_CMD_PARITY_EN
    tests_run++; if (bus.parity_err !== 1'b1 || p !== 0 || v !== 0 || bus.busy !== 1'b0) begin tests_failed++; $display("FAIL par_bad: perr %b pulses %0d valid %0d busy %b expected 1 0 0 0", bus.parity_err, p, v, bus.busy); end
`else
    tests_run++; if (bus.parity_err !== 1'b0 || a !== 4'b0100 || p !== 1 || v !== 1) begin tests_failed++; $display("FAIL par_off: perr %b act %b pulses %0d valid %0d expected 0 0100 1 1", bus.parity_err, a, p, v); end
`endif
    run_cmd(38'h24_0000_0001, 2'd2, a, n, p, v);
    tests_run++; if (a !== 4'b0100 || n !== 4'b0000 || p !== 1 || v !== 1) begin tests_failed++; $display("FAIL par_good: act %b noact %b pulses %0d valid %0d expected 0100 0000 1 1", a, n, p, v); end
`ifdef CPU_DEBUG_CMD_PARITY_EN
    tests_run++; if (bus.parity_err !== 1'b1) begin tests_failed++; $display("FAIL par_sticky: got %b expected 1", bus.parity_err); end
    bus.overrun_clr = 1'b1;
    step(1);
    bus.overrun_clr = 1'b0;
    tests_run++; if (bus.parity_err !== 1'b0) begin tests_failed++; $display("FAIL par_clear: got %b expected 0", bus.parity_err); end
`endif
  endtask

  initial begin
    bus.sr = '0; bus.ir_in = '0; bus.vs_udr = 1'b0; bus.vs_uir = 1'b0;
    bus.cmd_ready = 1'b0; bus.overrun_clr = 1'b0;
    test_reset();
    test_action();
    test_no_action_hold();
    test_overrun();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_parity();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
